// File: rtl/rf_ctrl_pkg.sv
// Shared sizing defaults and the grant-state encoding for the register-file write arbiter.
package rf_ctrl_pkg;

    localparam int INDEX_BIT_WIDTH = 4;
    localparam int DATA_BIT_WIDTH  = 32;
    localparam int N_REGS          = 1 << INDEX_BIT_WIDTH;

    typedef enum logic {
        PRI_MEM = 1'b0,
        PRI_ALU = 1'b1
    } grantState_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by decode reservations, cleared by accepted writebacks,
// with two combinational lookup ports for decode source operands.
module rf_scoreboard #(
    parameter int INDEX_BIT_WIDTH = rf_ctrl_pkg::INDEX_BIT_WIDTH,
    parameter int N_REGS          = (1 << INDEX_BIT_WIDTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       setEn,
    input  logic [INDEX_BIT_WIDTH-1:0] setIndex,
    input  logic                       clrEn,
    input  logic [INDEX_BIT_WIDTH-1:0] clrIndex,
    input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
    input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
    output logic                       busy1,
    output logic                       busy2
);

    logic [N_REGS-1:0] pending;

    // A reservation landing on the same edge as the retiring write keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (setEn && (setIndex == i[INDEX_BIT_WIDTH-1:0])) begin
                    pending[i] <= 1'b1;
                end else if (clrEn && (clrIndex == i[INDEX_BIT_WIDTH-1:0])) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (rdIndex1 == i[INDEX_BIT_WIDTH-1:0]) busy1 = pending[i];
            if (rdIndex2 == i[INDEX_BIT_WIDTH-1:0]) busy2 = pending[i];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto one registered register-file write port.
// Define RF_ARB_ROUND_ROBIN_EN for alternating priority; otherwise mem always wins.
module regfile_write_arbiter #(
    parameter int INDEX_BIT_WIDTH = rf_ctrl_pkg::INDEX_BIT_WIDTH,
    parameter int DATA_BIT_WIDTH  = rf_ctrl_pkg::DATA_BIT_WIDTH,
    parameter int N_REGS          = (1 << INDEX_BIT_WIDTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [INDEX_BIT_WIDTH-1:0] alu_index,
    input  logic [DATA_BIT_WIDTH-1:0]  alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [INDEX_BIT_WIDTH-1:0] mem_index,
    input  logic [DATA_BIT_WIDTH-1:0]  mem_data,
    output logic                       mem_ready,
    input  logic                       rsv_en,
    input  logic [INDEX_BIT_WIDTH-1:0] rsv_index,
    input  logic [INDEX_BIT_WIDTH-1:0] rd_index1,
    input  logic [INDEX_BIT_WIDTH-1:0] rd_index2,
    output logic                       rd_busy1,
    output logic                       rd_busy2,
    output logic                       wrtEn,
    output logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
    output logic [DATA_BIT_WIDTH-1:0]  dataIn
);

    import rf_ctrl_pkg::*;

    logic                       aluGrant;
    logic                       memGrant;
    logic                       xfer;
    logic [INDEX_BIT_WIDTH-1:0] selIndex;
    logic [DATA_BIT_WIDTH-1:0]  selData;

`ifdef RF_ARB_ROUND_ROBIN_EN
    grantState_e grantState;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grantState <= PRI_MEM;
        end else if (memGrant) begin
            grantState <= PRI_ALU;
        end else if (aluGrant) begin
            grantState <= PRI_MEM;
        end
    end
`endif

    // Grants are suppressed during reset so neither requester sees ready.
    always_comb begin
        aluGrant = 1'b0;
        memGrant = 1'b0;
        if (!reset) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
            if (alu_valid && mem_valid) begin
                memGrant = (grantState == PRI_MEM);
                aluGrant = (grantState == PRI_ALU);
            end else begin
                memGrant = mem_valid;
                aluGrant = alu_valid;
            end
`else
            memGrant = mem_valid;
            aluGrant = alu_valid && !mem_valid;
`endif
        end
    end

    assign alu_ready = aluGrant;
    assign mem_ready = memGrant;
    assign xfer      = aluGrant || memGrant;
    assign selIndex  = memGrant ? mem_index : alu_index;
    assign selData   = memGrant ? mem_data  : alu_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrtEn    <= 1'b0;
            wrtIndex <= '0;
            dataIn   <= '0;
        end else begin
            wrtEn <= xfer;
            if (xfer) begin
                wrtIndex <= selIndex;
                dataIn   <= selData;
            end
        end
    end

    rf_scoreboard #(
        .INDEX_BIT_WIDTH(INDEX_BIT_WIDTH),
        .N_REGS         (N_REGS)
    ) uScoreboard (
        .clk     (clk),
        .reset   (reset),
        .setEn   (rsv_en),
        .setIndex(rsv_index),
        .clrEn   (xfer),
        .clrIndex(selIndex),
        .rdIndex1(rd_index1),
        .rdIndex2(rd_index2),
        .busy1   (rd_busy1),
        .busy2   (rd_busy2)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus queues expected writes, a monitor retires them.
module tb_regfile_write_arbiter;

    localparam int IW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0;
    logic [IW-1:0] alu_index = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [IW-1:0] mem_index = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready;
    logic          rsv_en = 1'b0;
    logic [IW-1:0] rsv_index = '0;
    logic [IW-1:0] rd_index1 = '0;
    logic [IW-1:0] rd_index2 = '0;
    logic          rd_busy1;
    logic          rd_busy2;
    logic          wrtEn;
    logic [IW-1:0] wrtIndex;
    logic [DW-1:0] dataIn;

    int total = 0;
    int bad = 0;
    logic [IW+DW-1:0] expQ[$];

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .INDEX_BIT_WIDTH(IW),
        .DATA_BIT_WIDTH (DW),
        .N_REGS         (1 << IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .alu_valid(alu_valid),
        .alu_index(alu_index),
        .alu_data (alu_data),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid),
        .mem_index(mem_index),
        .mem_data (mem_data),
        .mem_ready(mem_ready),
        .rsv_en   (rsv_en),
        .rsv_index(rsv_index),
        .rd_index1(rd_index1),
        .rd_index2(rd_index2),
        .rd_busy1 (rd_busy1),
        .rd_busy2 (rd_busy2),
        .wrtEn    (wrtEn),
        .wrtIndex (wrtIndex),
        .dataIn   (dataIn)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request cycle: drive, check readies, queue whatever write should be accepted.
    task automatic vec(input string nm,
                       input logic av, input logic [IW-1:0] ai, input logic [DW-1:0] ad,
                       input logic mv, input logic [IW-1:0] mi, input logic [DW-1:0] md,
                       input logic expAlu, input logic expMem);
        alu_valid = av; alu_index = ai; alu_data = ad;
        mem_valid = mv; mem_index = mi; mem_data = md;
        #1;
        check({nm, "/alu_ready"}, alu_ready, expAlu);
        check({nm, "/mem_ready"}, mem_ready, expMem);
        if (expMem) expQ.push_back({mi, md});
        else if (expAlu) expQ.push_back({ai, ad});
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && wrtEn) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got=%0h:%0h expected=none", wrtIndex, dataIn);
            end else begin
                logic [IW+DW-1:0] e;
                e = expQ.pop_front();
                if ({wrtIndex, dataIn} !== e) begin
                    bad++;
                    $display("FAIL write_port got=%0h:%0h expected=%0h:%0h",
                             wrtIndex, dataIn, e[IW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with both requesters asserting valid.
        #1 reset = 1'b1;
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        check("rst/wrtEn", wrtEn, 0);
        check("rst/wrtIndex", wrtIndex, 0);
        check("rst/dataIn", dataIn, 0);
        check("rst/alu_ready", alu_ready, 0);
        check("rst/mem_ready", mem_ready, 0);
        check("rst/busy1", rd_busy1, 0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // ALU alone is granted immediately; port holds its value on an idle cycle.
        vec("alu_only", 1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 1, 0);
        check("alu_only/wrtEn", wrtEn, 1);
        vec("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        check("idle/wrtEn", wrtEn, 0);
        check("idle/hold_index", wrtIndex, 3);
        check("idle/hold_data", dataIn, 32'hDEADBEEF);

        // Both requesters contending.
`ifdef RF_ARB_ROUND_ROBIN_EN
        vec("both1", 1, 4'd4, 32'hA1, 1, 4'd1, 32'hB1, 0, 1);
        vec("both2", 1, 4'd4, 32'hA1, 1, 4'd1, 32'hB2, 1, 0);
        vec("both3", 1, 4'd4, 32'hA2, 1, 4'd1, 32'hB2, 0, 1);
        vec("both4", 1, 4'd4, 32'hA2, 1, 4'd1, 32'hB3, 1, 0);
        vec("mem_tail", 0, 0, 0, 1, 4'd1, 32'hB3, 0, 1);
`else
        vec("both1", 1, 4'd4, 32'hA1, 1, 4'd1, 32'hB1, 0, 1);
        vec("both2", 1, 4'd4, 32'hA1, 1, 4'd1, 32'hB2, 0, 1);
        vec("both3", 1, 4'd4, 32'hA1, 1, 4'd1, 32'hB3, 0, 1);
        vec("both4", 1, 4'd4, 32'hA1, 1, 4'd1, 32'hB4, 0, 1);
        vec("alu_tail", 1, 4'd4, 32'hA1, 0, 0, 0, 1, 0);
`endif

        // Reserve 5, stays busy until the mem write to 5 is accepted.
        rsv_en = 1'b1; rsv_index = 4'd5;
        tick();
        rsv_en = 1'b0; rd_index1 = 4'd5;
        #1 check("rsv5/busy_a", rd_busy1, 1);
        tick();
        check("rsv5/busy_b", rd_busy1, 1);
        vec("mem5", 0, 0, 0, 1, 4'd5, 32'h55, 0, 1);
        check("rsv5/busy_after", rd_busy1, 0);
        check("rsv5/wrtEn", wrtEn, 1);
        check("rsv5/wrtIndex", wrtIndex, 5);

        // Reservation of 7 on the same edge its write retires: set wins.
        rd_index2 = 4'd7;
        #1 check("rsv7/busy_before", rd_busy2, 0);
        rsv_en = 1'b1; rsv_index = 4'd7;
        vec("alu7", 1, 4'd7, 32'h77, 0, 0, 0, 1, 0);
        rsv_en = 1'b0;
        check("rsv7/busy_after", rd_busy2, 1);
        vec("alu7_clear", 1, 4'd7, 32'h70, 0, 0, 0, 1, 0);
        check("rsv7/busy_cleared", rd_busy2, 0);

        // Same destination from both sides: serialised, mem first.
        vec("same_idx_a", 1, 4'd2, 32'h22, 1, 4'd2, 32'h11, 0, 1);
        vec("same_idx_b", 1, 4'd2, 32'h22, 0, 0, 0, 1, 0);
        check("same_idx/wrtEn", wrtEn, 1);

        // Reset in the cycle after an accept discards the in-flight write.
        rsv_en = 1'b1; rsv_index = 4'd9;
        tick();
        rsv_index = 4'd10;
        tick();
        rsv_en = 1'b0; rd_index1 = 4'd9; rd_index2 = 4'd10;
        #1;
        check("prerst/busy1", rd_busy1, 1);
        check("prerst/busy2", rd_busy2, 1);
        mem_valid = 1'b1; mem_index = 4'd6; mem_data = 32'h66;
        #1 check("prerst/mem_ready", mem_ready, 1);
        tick();
        mem_valid = 1'b0;
        check("prerst/wrtEn", wrtEn, 1);
        reset = 1'b1;
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        check("midrst/wrtEn", wrtEn, 0);
        check("midrst/wrtIndex", wrtIndex, 0);
        check("midrst/dataIn", dataIn, 0);
        check("midrst/busy1", rd_busy1, 0);
        check("midrst/busy2", rd_busy2, 0);
        check("midrst/alu_ready", alu_ready, 0);
        check("midrst/mem_ready", mem_ready, 0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("postrst/wrtEn", wrtEn, 0);
        vec("postrst_both", 1, 4'd8, 32'hC8, 1, 4'd9, 32'hD9, 0, 1);
        vec("postrst_alu", 1, 4'd8, 32'hC8, 0, 0, 0, 1, 0);
        check("postrst/busy1", rd_busy1, 0);
        tick(); tick();
        check("drain/queue_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter INDEX_BIT_WIDTH, default 4, meaning the register index width.
REQ-002 The block SHALL have parameter DATA_BIT_WIDTH, default 32, meaning the register data width.
REQ-003 The block SHALL have parameter N_REGS, default (1 << INDEX_BIT_WIDTH), meaning the number of architectural registers tracked.
REQ-004 The block SHALL have one clock and one reset; the reset is asynchronous and active-high.
REQ-005 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 alu_valid  input  1  the ALU writeback requester has a write pending.
REQ-008 alu_index, alu_data  input  INDEX_BIT_WIDTH / DATA_BIT_WIDTH  the ALU destination index and result.
REQ-009 alu_ready  output  1  the ALU write is accepted this cycle.
REQ-010 mem_valid, mem_index, mem_data, mem_ready: the same four signals, with the same widths and meanings, for the load writeback requester.
REQ-011 rsv_en, rsv_index  input  1 / INDEX_BIT_WIDTH  decode reserves a destination register.
REQ-012 rd_index1, rd_index2  input  INDEX_BIT_WIDTH each  the source indices being read by decode.
REQ-013 rd_busy1, rd_busy2  output  1 each  the corresponding source register has a write pending.
REQ-014 wrtEn, wrtIndex, dataIn  output  1 / INDEX_BIT_WIDTH / DATA_BIT_WIDTH  the registered single write port driven into the register file.

Function
REQ-015 Each cycle the block SHALL grant at most one requester; ready SHALL be combinational, and ready=1 only for the granted requester with valid=1.
REQ-016 A transfer SHALL occur when valid && ready; after asserting valid, a requester SHALL hold valid, index and data stable until ready.
REQ-017 An accepted transfer SHALL appear on wrtEn/wrtIndex/dataIn exactly 1 cycle later. When there is no transfer, wrtEn SHALL be 0 and wrtIndex/dataIn SHALL hold their previous values.
REQ-018 When only one requester is valid, it SHALL be granted in the same cycle.
REQ-019 Grant-state FSM with states PRI_MEM and PRI_ALU, entered as PRI_MEM from reset:
- When both requesters are valid, the requester named by the state SHALL be granted.
- After any grant, the state SHALL move to favour the other requester.
REQ-020 The scoreboard SHALL hold one pending bit per register.
- rsv_en SHALL set pending[rsv_index] at the clock edge.
- An accepted transfer SHALL clear pending[index] at the same edge.
- If a set and a clear target the same index in the same cycle, the set SHALL win.
REQ-021 rd_busyN SHALL equal pending[rd_indexN], combinationally. A write on the output port is forwarded by the register file, so it is not busy.
REQ-022 Decode SHALL NOT reserve an index whose pending bit is already set. Such a reservation leaves the bit set, it is cleared by the first write, and no error is flagged.
REQ-023 Two requesters valid with the same index SHALL still be serialised, one write per cycle, in arbitration order.

Reset
REQ-024 While reset=1, the block SHALL drive wrtEn=0, wrtIndex=0, dataIn=0, alu_ready=0, mem_ready=0, all pending bits 0, and FSM state PRI_MEM.
REQ-025 Reset asserted mid-operation SHALL discard the registered in-flight write; no write SHALL reach the register file on the first edge after reset deassertion.

Configuration
REQ-026 With macro RF_ARB_ROUND_ROBIN_EN defined, arbitration SHALL follow REQ-019.
REQ-027 Without RF_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with mem always winning. The FSM SHALL be removed and alu_ready SHALL equal alu_valid && !mem_valid.

Structure
REQ-028 Package rf_ctrl_pkg SHALL hold INDEX_BIT_WIDTH, DATA_BIT_WIDTH, N_REGS and the grant-state enumeration (PRI_MEM, PRI_ALU).
REQ-029 The scoreboard SHALL be the sub-module rf_scoreboard, with set, clear and two combinational read ports; arbitration and the output register SHALL stay in the top module.

Verification
REQ-030 ALU only (valid, index 3, data 0xDEADBEEF) -> alu_ready=1 in the same cycle; the next cycle wrtEn=1, wrtIndex=3, dataIn=0xDEADBEEF.
REQ-031 Both valid for 4 cycles (RR on) -> grants mem, alu, mem, alu; wrtEn=1 on 4 consecutive cycles. RR off -> mem granted every cycle and alu_ready=0 throughout.
REQ-032 rsv_en index 5, then rd_index1=5 -> rd_busy1=1 until mem write to index 5 is accepted; rd_busy1=0 in the cycle after acceptance, when wrtEn=1 and wrtIndex=5.
REQ-033 rsv_en index 7 in the same cycle that the ALU write to index 7 is accepted -> pending[7]=1 afterwards; rd_busy=1 when rd_index=7.
REQ-034 reset asserted in the cycle after an accept -> wrtEn=0 immediately, all rd_busy outputs=0, FSM=PRI_MEM; no write after deassertion.
REQ-035 Both requesters valid with index 2 (data 0x11 mem, 0x22 alu) -> two writes on consecutive cycles, 0x11 then 0x22 (RR on).
